// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared widths and entry types for the issue queue
package issue_pkg;

    localparam int TAG_W    = 6;
    localparam int ROB_W    = 6;
    localparam int DATA_W   = 32;
    localparam int ALUCTL_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              ready;
        logic [DATA_W-1:0] value;
    } src_t;

    typedef struct packed {
        logic                valid;
        logic [ALUCTL_W-1:0] alu_ctl;
        logic                alu_src;
        logic                is_for_lsq;
        logic [DATA_W-1:0]   imm;
        src_t                rs1;
        src_t                rs2;
        logic [TAG_W-1:0]    dest_tag;
        logic [ROB_W-1:0]    rob_index;
    } entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - dispatch, wakeup and FU issue signals of one issue queue
interface issue_queue_if #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 3
);
    import issue_pkg::*;

    logic                        dispatch_valid;
    logic                        dispatch_ready;
    logic [ALUCTL_W-1:0]         dispatch_ALUControl;
    logic                        dispatch_ALUSrc;
    logic                        dispatch_is_for_lsq;
    logic [DATA_W-1:0]           dispatch_imm;
    logic [TAG_W-1:0]            dispatch_rs1_tag;
    logic [TAG_W-1:0]            dispatch_rs2_tag;
    logic                        dispatch_rs1_ready;
    logic                        dispatch_rs2_ready;
    logic [DATA_W-1:0]           dispatch_rs1_value;
    logic [DATA_W-1:0]           dispatch_rs2_value;
    logic [TAG_W-1:0]            dispatch_tag_to_output;
    logic [ROB_W-1:0]            dispatch_rob_index;

    logic [NUM_WB-1:0]           wb_active;
    logic [TAG_W*NUM_WB-1:0]     wb_tag;
    logic [DATA_W*NUM_WB-1:0]    wb_value;

    logic                        fu_is_available;
    logic                        fu_write_enable;
    logic [ALUCTL_W-1:0]         fu_ALUControl;
    logic                        fu_ALUSrc;
    logic                        fu_is_for_lsq;
    logic [DATA_W-1:0]           fu_imm;
    logic [DATA_W-1:0]           fu_rs1_value;
    logic [DATA_W-1:0]           fu_rs2_value;
    logic [TAG_W-1:0]            fu_tag_to_output;
    logic [ROB_W-1:0]            fu_rob_index;

    logic [$clog2(DEPTH+1)-1:0]  count;

    modport master (
        output dispatch_valid, dispatch_ALUControl, dispatch_ALUSrc, dispatch_is_for_lsq,
               dispatch_imm, dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_ready,
               dispatch_rs2_ready, dispatch_rs1_value, dispatch_rs2_value,
               dispatch_tag_to_output, dispatch_rob_index,
               wb_active, wb_tag, wb_value, fu_is_available,
        input  dispatch_ready, fu_write_enable, fu_ALUControl, fu_ALUSrc, fu_is_for_lsq,
               fu_imm, fu_rs1_value, fu_rs2_value, fu_tag_to_output, fu_rob_index, count
    );

    modport slave (
        input  dispatch_valid, dispatch_ALUControl, dispatch_ALUSrc, dispatch_is_for_lsq,
               dispatch_imm, dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rs1_ready,
               dispatch_rs2_ready, dispatch_rs1_value, dispatch_rs2_value,
               dispatch_tag_to_output, dispatch_rob_index,
               wb_active, wb_tag, wb_value, fu_is_available,
        output dispatch_ready, fu_write_enable, fu_ALUControl, fu_ALUSrc, fu_is_for_lsq,
               fu_imm, fu_rs1_value, fu_rs2_value, fu_tag_to_output, fu_rob_index, count
    );

endinterface

// File: rtl/issue_queue_priority_enc.sv
// rtl/issue_queue_priority_enc.sv - lowest-set-bit encoder with found flag
module iq_priority_enc #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // Scanning downward lets the last hit, the lowest set bit, win.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - reservation station feeding one functional unit
module issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 3
) (
    input  logic         clk,
    input  logic         reset,
    issue_queue_if.slave iq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             q [DEPTH];
    entry_t             new_entry;
    entry_t             out_entry;
    logic [CNT_W-1:0]   count_r;
    logic [DEPTH-1:0]   valid_vec;
    logic [DEPTH-1:0]   ready_vec;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               has_free;
    logic               any_ready;
    logic               do_dispatch;
    logic               do_issue;

    // Lowest-numbered matching bus wins; a source that is already ready is left alone.
    function automatic src_t snoop(input src_t s);
        snoop = s;
        if (!s.ready) begin
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (iq.wb_active[k] && iq.wb_tag[k*TAG_W +: TAG_W] == s.tag) begin
                    snoop.ready = 1'b1;
                    snoop.value = iq.wb_value[k*DATA_W +: DATA_W];
                end
            end
        end
    endfunction

    iq_priority_enc #(.WIDTH(DEPTH)) u_alloc_enc (
        .req   (~valid_vec),
        .index (alloc_idx),
        .found (has_free)
    );

    iq_priority_enc #(.WIDTH(DEPTH)) u_sel_enc (
        .req   (ready_vec),
        .index (sel_idx),
        .found (any_ready)
    );

    assign iq.dispatch_ready = (count_r < CNT_W'(DEPTH));
    assign do_dispatch       = iq.dispatch_valid && iq.dispatch_ready && has_free;
    assign do_issue          = iq.fu_is_available && any_ready && !reset;

    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.alu_ctl    = iq.dispatch_ALUControl;
        new_entry.alu_src    = iq.dispatch_ALUSrc;
        new_entry.is_for_lsq = iq.dispatch_is_for_lsq;
        new_entry.imm        = iq.dispatch_imm;
        new_entry.rs1        = snoop('{tag: iq.dispatch_rs1_tag, ready: iq.dispatch_rs1_ready,
                                       value: iq.dispatch_rs1_value});
        new_entry.rs2        = snoop('{tag: iq.dispatch_rs2_tag, ready: iq.dispatch_rs2_ready,
                                       value: iq.dispatch_rs2_value});
        new_entry.dest_tag   = iq.dispatch_tag_to_output;
        new_entry.rob_index  = iq.dispatch_rob_index;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        entry_t nxt;

        assign valid_vec[i] = q[i].valid;
        assign ready_vec[i] = q[i].valid && q[i].rs1.ready && q[i].rs2.ready;

        // A freed slot keeps its fields; only the valid bit drops.
        always_comb begin
            nxt     = q[i];
            nxt.rs1 = snoop(q[i].rs1);
            nxt.rs2 = snoop(q[i].rs2);
            if (do_issue && sel_idx == IDX_W'(i)) begin
                nxt.valid = 1'b0;
            end
            if (do_dispatch && alloc_idx == IDX_W'(i)) begin
                nxt = new_entry;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                q[i] <= '0;
            end else begin
                q[i] <= nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(do_dispatch) - CNT_W'(do_issue);
        end
    end

    assign out_entry           = q[do_issue ? sel_idx : '0];
    assign iq.fu_write_enable  = do_issue;
    assign iq.fu_ALUControl    = out_entry.alu_ctl;
    assign iq.fu_ALUSrc        = out_entry.alu_src;
    assign iq.fu_is_for_lsq    = out_entry.is_for_lsq;
    assign iq.fu_imm           = out_entry.imm;
    assign iq.fu_rs1_value     = out_entry.rs1.value;
    assign iq.fu_rs2_value     = out_entry.rs2.value;
    assign iq.fu_tag_to_output = out_entry.dest_tag;
    assign iq.fu_rob_index     = out_entry.rob_index;
    assign iq.count            = count_r;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - randomized and directed bench for issue_queue
module tb_issue_queue;

    localparam int DEPTH  = 8;
    localparam int NUM_WB = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    issue_queue_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) iq ();

    issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk   (clk),
        .reset (reset),
        .iq    (iq)
    );

    typedef struct {
        bit          valid;
        logic [3:0]  ctl;
        bit          src;
        bit          lsq;
        logic [31:0] imm;
        logic [5:0]  t1, t2;
        bit          r1, r2;
        logic [31:0] v1, v2;
        logic [5:0]  dest, rob;
    } m_t;

    m_t m [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m[i].valid) c++;
        return c;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < DEPTH; i++) if (m[i].valid && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    function automatic bit wb_hit(input logic [5:0] tag, output logic [31:0] val);
        bit hit = 0;
        val = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (!hit && iq.wb_active[k] && iq.wb_tag[6*k +: 6] == tag) begin
                hit = 1;
                val = iq.wb_value[32*k +: 32];
            end
        end
        return hit;
    endfunction

    task automatic model_update(input int issued);
        int free_i = -1;
        int cnt = m_cnt();
        logic [31:0] v;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
            return;
        end
        for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].valid) free_i = i;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].valid && !m[i].r1 && wb_hit(m[i].t1, v)) begin m[i].r1 = 1; m[i].v1 = v; end
            if (m[i].valid && !m[i].r2 && wb_hit(m[i].t2, v)) begin m[i].r2 = 1; m[i].v2 = v; end
        end
        if (issued >= 0) m[issued].valid = 0;
        if (iq.dispatch_valid && cnt < DEPTH) begin
            m[free_i].valid = 1;
            m[free_i].ctl   = iq.dispatch_ALUControl;
            m[free_i].src   = iq.dispatch_ALUSrc;
            m[free_i].lsq   = iq.dispatch_is_for_lsq;
            m[free_i].imm   = iq.dispatch_imm;
            m[free_i].t1    = iq.dispatch_rs1_tag;
            m[free_i].t2    = iq.dispatch_rs2_tag;
            m[free_i].r1    = iq.dispatch_rs1_ready;
            m[free_i].r2    = iq.dispatch_rs2_ready;
            m[free_i].v1    = iq.dispatch_rs1_value;
            m[free_i].v2    = iq.dispatch_rs2_value;
            m[free_i].dest  = iq.dispatch_tag_to_output;
            m[free_i].rob   = iq.dispatch_rob_index;
            if (!m[free_i].r1 && wb_hit(m[free_i].t1, v)) begin m[free_i].r1 = 1; m[free_i].v1 = v; end
            if (!m[free_i].r2 && wb_hit(m[free_i].t2, v)) begin m[free_i].r2 = 1; m[free_i].v2 = v; end
        end
    endtask

    // Inputs are already driven (after a falling edge); check, clock, then advance the model.
    task automatic cycle();
        int s;
        bit exp_we;
        #1;
        s = m_sel();
        exp_we = !reset && iq.fu_is_available && (s >= 0);
        check("count", iq.count, m_cnt());
        check("dispatch_ready", iq.dispatch_ready, m_cnt() < DEPTH);
        check("fu_write_enable", iq.fu_write_enable, exp_we);
        check("fu_known", $isunknown({iq.fu_rs1_value, iq.fu_rs2_value, iq.fu_imm}), 0);
        if (exp_we && iq.fu_write_enable) begin
            check("fu_ALUControl", iq.fu_ALUControl, m[s].ctl);
            check("fu_ALUSrc", iq.fu_ALUSrc, m[s].src);
            check("fu_is_for_lsq", iq.fu_is_for_lsq, m[s].lsq);
            check("fu_imm", iq.fu_imm, m[s].imm);
            check("fu_rs1_value", iq.fu_rs1_value, m[s].v1);
            check("fu_rs2_value", iq.fu_rs2_value, m[s].v2);
            check("fu_tag_to_output", iq.fu_tag_to_output, m[s].dest);
            check("fu_rob_index", iq.fu_rob_index, m[s].rob);
        end
        @(posedge clk);
        model_update(exp_we ? s : -1);
        @(negedge clk);
    endtask

    task automatic idle();
        iq.dispatch_valid         = 0;
        iq.dispatch_ALUControl    = '0;
        iq.dispatch_ALUSrc        = 0;
        iq.dispatch_is_for_lsq    = 0;
        iq.dispatch_imm           = '0;
        iq.dispatch_rs1_tag       = '0;
        iq.dispatch_rs2_tag       = '0;
        iq.dispatch_rs1_ready     = 0;
        iq.dispatch_rs2_ready     = 0;
        iq.dispatch_rs1_value     = '0;
        iq.dispatch_rs2_value     = '0;
        iq.dispatch_tag_to_output = '0;
        iq.dispatch_rob_index     = '0;
        iq.wb_active              = '0;
        iq.wb_tag                 = '0;
        iq.wb_value               = '0;
    endtask

    task automatic disp(input logic [3:0] ctl, input bit src,
                        input logic [5:0] t1, input bit r1, input logic [31:0] v1,
                        input logic [5:0] t2, input bit r2, input logic [31:0] v2,
                        input logic [5:0] rob);
        iq.dispatch_valid         = 1;
        iq.dispatch_ALUControl    = ctl;
        iq.dispatch_ALUSrc        = src;
        iq.dispatch_is_for_lsq    = rob[0];
        iq.dispatch_imm           = 32'h100 + 32'(rob);
        iq.dispatch_rs1_tag       = t1;
        iq.dispatch_rs1_ready     = r1;
        iq.dispatch_rs1_value     = v1;
        iq.dispatch_rs2_tag       = t2;
        iq.dispatch_rs2_ready     = r2;
        iq.dispatch_rs2_value     = v2;
        iq.dispatch_tag_to_output = rob + 6'd1;
        iq.dispatch_rob_index     = rob;
    endtask

    task automatic wb(input int k, input logic [5:0] tag, input logic [31:0] val);
        iq.wb_active[k]      = 1;
        iq.wb_tag[6*k +: 6]  = tag;
        iq.wb_value[32*k +: 32] = val;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
        reset = 1;
        iq.fu_is_available = 0;
        idle();
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;
        #1;
        check("rst_count", iq.count, 0);
        check("rst_dispatch_ready", iq.dispatch_ready, 1);
        check("rst_fu_we", iq.fu_write_enable, 0);
        check("rst_fu_data", {iq.fu_rs1_value, iq.fu_rs2_value}, 0);
        check("rst_fu_imm", iq.fu_imm, 0);
        cycle();

        // both operands ready: issue the following cycle
        iq.fu_is_available = 1;
        disp(4'b0010, 0, 6'd1, 1, 32'd5, 6'd2, 1, 32'd7, 6'd1);
        cycle();
        idle();
        #1;
        check("add_we", iq.fu_write_enable, 1);
        check("add_rs1", iq.fu_rs1_value, 5);
        check("add_rs2", iq.fu_rs2_value, 7);
        cycle();
        check("add_count", iq.count, 0);

        // wakeup on bus 1 then issue one cycle later
        disp(4'b0011, 0, 6'd12, 0, 32'd0, 6'd3, 1, 32'h11, 6'd2);
        cycle();
        idle();
        #1;
        check("or_wait_we", iq.fu_write_enable, 0);
        cycle();
        wb(1, 6'd12, 32'hF0);
        #1;
        check("or_wake_cycle_we", iq.fu_write_enable, 0);
        cycle();
        idle();
        #1;
        check("or_we", iq.fu_write_enable, 1);
        check("or_rs1", iq.fu_rs1_value, 32'hF0);
        cycle();

        // same-cycle dispatch snoop
        disp(4'b0100, 0, 6'd4, 1, 32'h44, 6'd9, 0, 32'd0, 6'd3);
        wb(0, 6'd9, 32'h33);
        cycle();
        idle();
        #1;
        check("snoop_we", iq.fu_write_enable, 1);
        check("snoop_rs2", iq.fu_rs2_value, 32'h33);
        cycle();

        // fill to full, ignore a 9th dispatch, then free one
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'b0000, 0, 6'(20 + i), 0, 32'd0, 6'd5, 1, 32'd1, 6'(10 + i));
            cycle();
        end
        idle();
        #1;
        check("full_count", iq.count, 8);
        check("full_ready", iq.dispatch_ready, 0);
        disp(4'b0001, 0, 6'd1, 1, 32'd1, 6'd1, 1, 32'd1, 6'd40);
        cycle();
        idle();
        #1;
        check("full_ignored_count", iq.count, 8);
        wb(2, 6'd23, 32'hAB);
        cycle();
        idle();
        #1;
        check("full_issue_we", iq.fu_write_enable, 1);
        check("full_issue_rob", iq.fu_rob_index, 13);
        check("full_issue_rs1", iq.fu_rs1_value, 32'hAB);
        check("full_still_busy", iq.dispatch_ready, 0);
        cycle();
        check("full_freed_ready", iq.dispatch_ready, 1);
        check("full_freed_count", iq.count, 7);
        reset = 1;
        cycle();
        reset = 0;

        // entries 2 and 5 ready while the FU is busy
        iq.fu_is_available = 0;
        for (int i = 0; i < 6; i++) begin
            disp(4'b0101, 1, 6'(30 + i), (i == 2 || i == 5), 32'(i), 6'd0, 1, 32'd0, 6'(50 + i));
            cycle();
        end
        idle();
        #1;
        check("busy_no_issue", iq.fu_write_enable, 0);
        cycle();
        iq.fu_is_available = 1;
        #1;
        check("order_first", iq.fu_rob_index, 52);
        cycle();
        #1;
        check("order_second", iq.fu_rob_index, 55);
        cycle();

        // reset with four valid entries, one of them ready
        iq.fu_is_available = 0;
        wb(0, 6'd30, 32'h77);
        cycle();
        idle();
        #1;
        check("pre_reset_count", iq.count, 4);
        reset = 1;
        iq.fu_is_available = 1;
        #1;
        check("reset_cycle_we", iq.fu_write_enable, 0);
        cycle();
        reset = 0;
        #1;
        check("post_reset_we", iq.fu_write_enable, 0);
        check("post_reset_count", iq.count, 0);
        cycle();

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            idle();
            reset = ($urandom_range(0, 149) == 0);
            iq.fu_is_available = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 1) begin
                bit src = 1'($urandom_range(0, 1));
                disp(4'($urandom), src,
                     6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                     6'($urandom_range(0, 7)), src | 1'($urandom_range(0, 1)), $urandom,
                     6'($urandom));
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if ($urandom_range(0, 2) == 0) wb(k, 6'($urandom_range(0, 7)), $urandom);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Reservation station that feeds one `FunctionalUnit`, the producer side of its issue interface.
- Accepts dispatched ALU micro-ops with possibly-unready source operands.
- Snoops the result wakeup buses to capture missing operand values.
- Issues one ready micro-op per cycle into the FU whenever the FU reports `is_available`.
- Sits between rename/dispatch and the FU; one instance per FU.

## Interface
Parameters:
- `DEPTH`, 8: number of entries (power of two, ≥2).
- `NUM_WB`, 3: number of wakeup buses snooped.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dispatch_valid`  in  1  new micro-op offered this cycle.
- `dispatch_ready`  out  1  queue can accept (registered not-full).
- `dispatch_ALUControl`  in  4  ALU op code.
- `dispatch_ALUSrc`  in  1  0 = rs1 op rs2, 1 = rs1 op imm.
- `dispatch_is_for_lsq`  in  1  result goes to LSQ address bus.
- `dispatch_imm`  in  32  immediate.
- `dispatch_rs1_tag`, `dispatch_rs2_tag`  in  6 each  physical source tags.
- `dispatch_rs1_ready`, `dispatch_rs2_ready`  in  1 each  operand value already valid.
- `dispatch_rs1_value`, `dispatch_rs2_value`  in  32 each  operand values (valid when ready).
- `dispatch_tag_to_output`  in  6  destination tag.
- `dispatch_rob_index`  in  6  ROB index.
- `wb_active`  in  NUM_WB  per-bus broadcast valid.
- `wb_tag`  in  6·NUM_WB  packed tags, bus k at [6k+5:6k].
- `wb_value`  in  32·NUM_WB  packed values, bus k at [32k+31:32k].
- `fu_is_available`  in  1  FU can accept this cycle.
- `fu_write_enable`  out  1  issue strobe to FU.
- `fu_ALUControl`  out  4  issued op.
- `fu_ALUSrc`  out  1
- `fu_is_for_lsq`  out  1
- `fu_imm`  out  32
- `fu_rs1_value`, `fu_rs2_value`  out  32 each
- `fu_tag_to_output`  out  6
- `fu_rob_index`  out  6
- `count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry state: valid, op fields, per source {tag, ready, value}.
- Dispatch: on `dispatch_valid && dispatch_ready`, write the lowest-indexed free entry, using the incoming ready flags and values.
- Dispatch-cycle snoop: if an incoming not-ready source tag matches an active wb bus in the same cycle, store that source as ready with the bus value.
- Wakeup: each cycle, every valid entry with a not-ready source whose tag equals an active `wb_tag[k]` sets ready and latches `wb_value[k]`.
  - If several buses match the same tag, the lowest k wins.
  - Already-ready sources are never overwritten.
- Ready entry: valid with both sources ready.
  - rs2 readiness is still required when `ALUSrc` = 1. Dispatch sets rs2_ready = 1 for immediate ops.
- Select: lowest-indexed ready entry, computed from registered state only. There is no wakeup-to-issue bypass.
- Issue: `fu_write_enable` = `fu_is_available` && any ready entry.
  - `fu_*` fields are driven combinationally from the selected entry.
  - The entry is freed at the same clock edge.
  - When `fu_write_enable` = 0, `fu_*` fields are don't-care but must be driven (not X). They are driven from entry 0.
- `dispatch_ready` = registered `count` < DEPTH. An issue in the same cycle does not make room for a same-cycle dispatch when full.
- Simultaneous issue and dispatch when not full: both happen, `count` unchanged. The freed slot is reusable from the next cycle.
- `dispatch_valid` while `dispatch_ready` = 0 is ignored; no state change.

## Timing
- Reset values:
  - all entries invalid; `count` = 0; `dispatch_ready` = 1; `fu_write_enable` = 0.
  - `fu_*` data outputs = 0.
- Reset mid-operation discards all entries; no issue occurs on the reset cycle.
- Latencies:
  - Dispatch with both operands ready: issue possible in cycle N+1 at the earliest.
  - Wakeup in cycle N: dependent entry issues in cycle N+1 at the earliest.
- Issue depends combinationally on `fu_is_available`. The FU drives that signal from its registers, so there is no loop.
- At most one dispatch and one issue per cycle.

## Structure
- Shared package `issue_pkg`:
  - `TAG_W` = 6, `ROB_W` = 6, `DATA_W` = 32, `ALUCTL_W` = 4.
  - Entry struct typedef.
- Sub-module `iq_priority_enc`: lowest-set-bit encoder with found flag. Used for both free-entry allocation and ready-entry selection.
- Per-entry wakeup compare is inline generate logic.

## Test plan
- Reset, then dispatch ADD (0010), rs1 = 5, rs2 = 7, both ready, `fu_is_available` = 1 → cycle+1: `fu_write_enable` = 1, `fu_rs1_value` = 5, `fu_rs2_value` = 7; `count` returns to 0.
- Dispatch OR with rs1_tag = 12 not ready; later `wb_active[1]` = 1, tag 12, value 0xF0 → issue exactly one cycle after the wakeup, `fu_rs1_value` = 0xF0.
- Dispatch with rs2_tag = 9 not ready while bus 0 broadcasts tag 9 / 0x33 in the same cycle → entry captures 0x33 and issues next cycle.
- Fill 8 entries with not-ready ops → `dispatch_ready` = 0, `count` = 8, a 9th `dispatch_valid` is ignored. Wake one entry → it issues, and `dispatch_ready` = 1 the cycle after the issue.
- Hold `fu_is_available` = 0 with entries 2 and 5 ready → no issue. Raise it → entry 2 issues first, then entry 5.
- Assert `reset` with 4 valid entries and one ready → no `fu_write_enable` on or after reset, `count` = 0.
